// File: rtl/rx_bus_pkg.sv
// rx_bus_pkg: shared state encoding, header layout and defaults for the rx header parser.
package rx_bus_pkg;
  typedef enum logic [2:0] {
    IDLE, RD_ID, RD_TYPE, RD_SN, CAP, HIT, CHK, WAIT_COM
  } rx_state_t;
  localparam logic [7:0] HDR_OFS_ID   = 8'd0;
  localparam logic [7:0] HDR_OFS_TYPE = 8'd1;
  localparam logic [7:0] HDR_OFS_SN   = 8'd2;
  localparam int ID_NUM_DEF = 72;
  localparam int COM_TO_DEF = 8;
  function automatic logic [7:0] sn_next(input logic [7:0] sn);
    return sn + 8'd1;
  endfunction
endpackage

// File: rtl/rx_sn_table.sv
// rx_sn_table: per-id {valid, expected sn} store, combinational read, one synchronous write port.
module rx_sn_table import rx_bus_pkg::*; #(
  parameter int ID_NUM = ID_NUM_DEF,
  parameter int AW     = (ID_NUM > 1) ? $clog2(ID_NUM) : 1
) (
  input  logic          sys_clk,
  input  logic          glbl_rst_n,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_valid,
  output logic [7:0]    rd_exp,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_exp
);
  logic       valid_q [ID_NUM];
  logic [7:0] exp_q   [ID_NUM];
  assign rd_valid = valid_q[rd_addr];
  assign rd_exp   = exp_q[rd_addr];
  always_ff @(posedge sys_clk or negedge glbl_rst_n) begin
    if (!glbl_rst_n) begin
      for (int i = 0; i < ID_NUM; i++) begin
        valid_q[i] <= 1'b0;
        exp_q[i]   <= 8'h00;
      end
    end else if (wr_en) begin
      valid_q[wr_addr] <= 1'b1;
      exp_q[wr_addr]   <= wr_exp;
    end
  end
endmodule

// File: rtl/rx_hdr_parse.sv
// rx_hdr_parse: reads the 3-byte frame header from rx RAM, checks the sequence number
// against the per-id table and commits the next expected sn on an ack/pass pulse.
module rx_hdr_parse import rx_bus_pkg::*; #(
  parameter logic [7:0] HDR_BASE = 8'h00,
  parameter int         ID_NUM   = ID_NUM_DEF,
  parameter int         COM_TO   = COM_TO_DEF
) (
  input  logic       sys_clk,
  input  logic       glbl_rst_n,
  input  logic       load_rd_en,
  output logic       ram_rd_en,
  output logic [7:0] ram_rd_addr,
  input  logic [7:0] ram_rd_data,
  output logic       got_frame,
  output logic [7:0] frame_id,
  output logic [7:0] frame_type,
  output logic [7:0] frame_sn,
  output logic       sn_error,
  input  logic       ack_rd_en,
  input  logic       pass_rd_en,
  output logic       busy
);
  localparam int AW = (ID_NUM > 1) ? $clog2(ID_NUM) : 1;
  localparam int CW = $clog2(COM_TO + 1);
  rx_state_t     state;
  logic [CW-1:0] to_cnt;
  logic          in_range, tbl_valid, commit, tbl_wr;
  logic [7:0]    tbl_exp;
  assign in_range = {1'b0, frame_id} < 9'(ID_NUM);
  assign commit   = ack_rd_en | pass_rd_en;
  // a reload in the same cycle as a commit abandons the frame, so it wins
  assign tbl_wr   = (state == WAIT_COM) & commit & ~load_rd_en & in_range;
  rx_sn_table #(.ID_NUM(ID_NUM), .AW(AW)) u_tbl (
    .sys_clk    (sys_clk),
    .glbl_rst_n (glbl_rst_n),
    .rd_addr    (frame_id[AW-1:0]),
    .rd_valid   (tbl_valid),
    .rd_exp     (tbl_exp),
    .wr_en      (tbl_wr),
    .wr_addr    (frame_id[AW-1:0]),
    .wr_exp     (sn_next(frame_sn))
  );
  always_ff @(posedge sys_clk or negedge glbl_rst_n) begin
    if (!glbl_rst_n) begin
      state       <= IDLE;
      ram_rd_en   <= 1'b0;
      ram_rd_addr <= 8'h00;
      got_frame   <= 1'b0;
      frame_id    <= 8'h00;
      frame_type  <= 8'h00;
      frame_sn    <= 8'h00;
      sn_error    <= 1'b0;
      busy        <= 1'b0;
      to_cnt      <= '0;
    end else begin
      got_frame <= 1'b0;
      sn_error  <= 1'b0;
      ram_rd_en <= 1'b0;
      case (state)
        IDLE: if (load_rd_en) begin
          state       <= RD_ID;
          ram_rd_en   <= 1'b1;
          ram_rd_addr <= HDR_BASE + HDR_OFS_ID;
          busy        <= 1'b1;
        end
        RD_ID: begin
          state       <= RD_TYPE;
          ram_rd_en   <= 1'b1;
          ram_rd_addr <= HDR_BASE + HDR_OFS_TYPE;
        end
        RD_TYPE: begin
          frame_id    <= ram_rd_data;
          state       <= RD_SN;
          ram_rd_en   <= 1'b1;
          ram_rd_addr <= HDR_BASE + HDR_OFS_SN;
        end
        RD_SN: begin
          frame_type <= ram_rd_data;
          state      <= CAP;
        end
        CAP: begin
          frame_sn  <= ram_rd_data;
          got_frame <= 1'b1;
          state     <= (in_range && tbl_valid) ? HIT : CHK;
        end
        HIT: begin
          sn_error <= frame_sn != tbl_exp;
          to_cnt   <= '0;
          state    <= WAIT_COM;
        end
        CHK: begin
          to_cnt <= '0;
          state  <= WAIT_COM;
        end
        WAIT_COM: begin
          if (load_rd_en) begin
            state       <= RD_ID;
            ram_rd_en   <= 1'b1;
            ram_rd_addr <= HDR_BASE + HDR_OFS_ID;
          end else if ((commit && in_range) || to_cnt == CW'(COM_TO - 1)) begin
            state  <= IDLE;
            busy   <= 1'b0;
            to_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rx_hdr_parse.sv
// tb_rx_hdr_parse: directed and random frames checked against a per-id sequence table model.
module tb_rx_hdr_parse;
  localparam logic [7:0] HDR = 8'h40;
  localparam int IDN = 72;
  logic       sys_clk, glbl_rst_n, load_rd_en, ram_rd_en, got_frame, sn_error;
  logic       ack_rd_en, pass_rd_en, busy;
  logic [7:0] ram_rd_addr, ram_rd_data, frame_id, frame_type, frame_sn;
  logic [7:0] ram [256];
  bit         m_valid [256];
  logic [7:0] m_exp [256];
  int         checks = 0, errors = 0;

  rx_hdr_parse #(.HDR_BASE(HDR), .ID_NUM(IDN), .COM_TO(8)) dut (
    .sys_clk(sys_clk), .glbl_rst_n(glbl_rst_n), .load_rd_en(load_rd_en),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .got_frame(got_frame), .frame_id(frame_id), .frame_type(frame_type),
    .frame_sn(frame_sn), .sn_error(sn_error), .ack_rd_en(ack_rd_en),
    .pass_rd_en(pass_rd_en), .busy(busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial ram_rd_data = 8'h00;
  always @(posedge sys_clk) if (ram_rd_en) ram_rd_data <= ram[ram_rd_addr];

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear;
    for (int i = 0; i < 256; i++) begin
      m_valid[i] = 1'b0;
      m_exp[i]   = 8'h00;
    end
  endtask

  // ck: commit cycle after load (0 none), sel: 0 ack / 1 pass / 2 both,
  // nk: stray load inside the read sequence, rk: reload cycle in the wait, pre: load already issued
  task automatic do_frame(input logic [7:0] id, input logic [7:0] ty, input logic [7:0] sn,
                          input int ck, input int sel, input int nk, input int rk, input bit pre);
    bit in_rng, err, acc;
    int end_k, last_k;
    in_rng = id < IDN;
    err    = in_rng && m_valid[id] && (m_exp[id] != sn);
    acc    = in_rng && ck >= 6 && ck <= 13;
    end_k  = acc ? ck : 13;
    last_k = (rk != 0) ? rk : 16;
    ram[HDR] = id;
    ram[HDR + 8'd1] = ty;
    ram[HDR + 8'd2] = sn;
    if (!pre) begin
      load_rd_en = 1'b1;
      tick;
      load_rd_en = 1'b0;
    end
    for (int k = 1; k <= last_k; k++) begin
      chk($sformatf("rd_en k%0d", k), ram_rd_en, k <= 3);
      if (k <= 3) chk($sformatf("rd_addr k%0d", k), ram_rd_addr, HDR + 8'(k - 1));
      chk($sformatf("got_frame k%0d", k), got_frame, k == 5);
      chk($sformatf("sn_error k%0d", k), sn_error, k == 6 && err);
      chk($sformatf("busy k%0d", k), busy, k <= end_k);
      if (k >= 3) chk($sformatf("frame_id k%0d", k), frame_id, id);
      if (k >= 4) chk($sformatf("frame_type k%0d", k), frame_type, ty);
      if (k >= 5) chk($sformatf("frame_sn k%0d", k), frame_sn, sn);
      load_rd_en = (k == nk) || (k == rk);
      ack_rd_en  = (k == ck) && sel != 1;
      pass_rd_en = (k == ck) && sel != 0;
      if (k == ck && acc) begin
        m_valid[id] = 1'b1;
        m_exp[id]   = sn + 8'd1;
      end
      tick;
      load_rd_en = 1'b0;
      ack_rd_en  = 1'b0;
      pass_rd_en = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] id, ty, sn;
    int ck, rk;
    bit pre;
    model_clear();
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    glbl_rst_n = 1'b0;
    load_rd_en = 1'b0;
    ack_rd_en  = 1'b0;
    pass_rd_en = 1'b0;
    repeat (3) tick;
    chk("rst busy", busy, 0);
    chk("rst got_frame", got_frame, 0);
    chk("rst ram_rd_en", ram_rd_en, 0);
    chk("rst frame_id", frame_id, 0);
    chk("rst sn_error", sn_error, 0);
    glbl_rst_n = 1'b1;
    tick;
    // first frame on id 30, then a committed expected of 6
    do_frame(8'd30, 8'h32, 8'h05, 10, 0, 0, 0, 0);
    chk("exp30 after first", dut.u_tbl.exp_q[30], 8'h06);
    chk("valid30 after first", dut.u_tbl.valid_q[30], 1);
    do_frame(8'd30, 8'h32, 8'h07, 0, 0, 0, 0, 0);
    chk("exp30 after timeout", dut.u_tbl.exp_q[30], 8'h06);
    do_frame(8'd30, 8'h11, 8'hFE, 7, 0, 0, 0, 0);
    chk("exp30 ff", dut.u_tbl.exp_q[30], 8'hFF);
    do_frame(8'd30, 8'h11, 8'hFF, 8, 1, 0, 0, 0);
    chk("exp30 wrap", dut.u_tbl.exp_q[30], 8'h00);
    do_frame(8'd30, 8'h11, 8'h00, 0, 0, 0, 0, 0);
    do_frame(8'd200, 8'h22, 8'h09, 8, 0, 0, 0, 0);
    chk("exp30 after id200", dut.u_tbl.exp_q[30], m_exp[30]);
    do_frame(8'd31, 8'h01, 8'h10, 6, 2, 0, 0, 0);
    chk("exp31 both", dut.u_tbl.exp_q[31], 8'h11);
    do_frame(8'd40, 8'h02, 8'h03, 0, 0, 3, 9, 0);
    chk("valid40 abandoned", dut.u_tbl.valid_q[40], 0);
    do_frame(8'd30, 8'h03, 8'h04, 13, 0, 0, 0, 1);
    chk("exp30 after restart", dut.u_tbl.exp_q[30], 8'h05);
    // reset in the middle of a parse
    ram[HDR] = 8'd30;
    load_rd_en = 1'b1;
    tick;
    load_rd_en = 1'b0;
    repeat (3) tick;
    glbl_rst_n = 1'b0;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst frame_id", frame_id, 0);
    chk("midrst ram_rd_en", ram_rd_en, 0);
    tick;
    glbl_rst_n = 1'b1;
    model_clear();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("postrst got_frame %0d", k), got_frame, 0);
      chk($sformatf("postrst sn_error %0d", k), sn_error, 0);
      chk($sformatf("postrst busy %0d", k), busy, 0);
      tick;
    end
    chk("postrst valid30", dut.u_tbl.valid_q[30], 0);
    chk("postrst exp30", dut.u_tbl.exp_q[30], 0);
    do_frame(8'd30, 8'h32, 8'h09, 0, 0, 0, 0, 0);
    // random traffic over a few ids plus out-of-range ones
    pre = 1'b0;
    for (int i = 0; i < 150; i++) begin
      id = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(IDN, 255)) : 8'($urandom_range(0, 5));
      ty = 8'($urandom);
      sn = (m_valid[id] && $urandom_range(0, 1) == 1) ? m_exp[id] : 8'($urandom);
      ck = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 16));
      rk = (i < 149 && $urandom_range(0, 5) == 0) ? int'($urandom_range(6, 13)) : 0;
      if (rk != 0) ck = 0;
      do_frame(id, ty, sn, ck, int'($urandom_range(0, 2)), int'($urandom_range(0, 5)), rk, pre);
      pre = rk != 0;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
